// File: rtl/periph_bus_pkg.sv
// periph_bus_pkg: shared types and address map for the peripheral bus arbiter.
//   owner_e : which master, if any, currently holds the bus lock
//   mid_t   : master id (0 = CPU data port, 1 = auxiliary master)
//   ADDR_*  : peripheral register byte addresses
package periph_bus_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    M0   = 2'd1,
    M1   = 2'd2
  } owner_e;

  typedef logic mid_t;

  localparam logic [31:0] ADDR_TH       = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL       = ADDR_TH + 32'h04;
  localparam logic [31:0] ADDR_TCON     = ADDR_TH + 32'h08;
  localparam logic [31:0] ADDR_LED      = ADDR_TH + 32'h0C;
  localparam logic [31:0] ADDR_SWITCH   = ADDR_TH + 32'h10;
  localparam logic [31:0] ADDR_DIGI     = ADDR_TH + 32'h14;
  localparam logic [31:0] ADDR_UART_TXD = ADDR_TH + 32'h18;
  localparam logic [31:0] ADDR_UART_RXD = ADDR_TH + 32'h1C;
  localparam logic [31:0] ADDR_UART_CON = ADDR_TH + 32'h20;

endpackage

// File: rtl/periph_bus_arbiter_arb.sv
// arb2_rr_lock: two-master round-robin arbiter with a bounded bus lock.
//   clk_i, reset_i : clock, synchronous active-high reset
//   req_i[1:0]     : per-master request (bit = master id)
//   lock_i[1:0]    : per-master "keep ownership after this transfer"
//   gnt_o[1:0]     : combinational grant; accept = req & gnt at the edge
module arb2_rr_lock
  import periph_bus_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  owner_e        owner_q, owner_d;
  mid_t          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  mid_t own_id;
  logic owned;
  logic acc;
  mid_t win;

  // An owner that drops req gives up the lock in that same cycle, so the
  // lock is only effective while the owner is actually requesting.
  always_comb begin
    own_id = (owner_q == M1);
    owned  = (owner_q != NONE) && req_i[own_id];
    gnt_o  = '0;
    if (!reset_i) begin
      if (owned)               gnt_o[own_id]  = 1'b1;
      else if (req_i == 2'b11) gnt_o[~last_q] = 1'b1;
      else                     gnt_o          = req_i;
    end
    acc = |(req_i & gnt_o);
    win = gnt_o[1];
  end

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if ((owner_q != NONE) && !owned) begin
      owner_d = NONE;
      cnt_d   = '0;
    end
    if (acc) begin
      last_d = win;
      if (owned) begin
        // The grant that brings the count to MAX_LOCK is the last locked one;
        // last_d = owner then hands the next contended cycle to the other side.
        if (!lock_i[win] || (cnt_q == CW'(MAX_LOCK - 1))) begin
          owner_d = NONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (lock_i[win]) begin
        owner_d = win ? M1 : M0;
        cnt_d   = CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_q  <= 1'b1;
      owner_q <= NONE;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master front end for the 0x4000_0000 peripheral bus.
//   clk_i, reset_i              : clock, synchronous active-high reset
//   mN_req_i/wr_i/addr_i/wdata_i/lock_i : master N command
//   mN_gnt_o                    : combinational grant
//   mN_rvalid_o, mN_rdata_o     : one-cycle read response to the issuing master
//   rd_o, wr_o, addr_o, wdata_o : registered peripheral command (one cycle)
//   rdata_i                     : peripheral read data, combinational from rd/addr
// Pipeline: accept at edge k -> bus cycle k+1 -> response cycle k+2.
module periph_bus_arbiter
  import periph_bus_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          m0_req_i,
  input  logic          m0_wr_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  input  logic          m0_lock_i,
  output logic          m0_gnt_o,
  output logic          m0_rvalid_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_wr_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  input  logic          m1_lock_i,
  output logic          m1_gnt_o,
  output logic          m1_rvalid_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          rd_o,
  output logic          wr_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  input  logic [DW-1:0] rdata_i
);

  logic [1:0] req, gnt;
  logic       acc;
  mid_t       sel;

  arb2_rr_lock #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (req),
    .lock_i ({m1_lock_i, m0_lock_i}),
    .gnt_o  (gnt)
  );

  assign req      = {m1_req_i, m0_req_i};
  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];
  assign acc      = |(req & gnt);
  assign sel      = gnt[1];

  logic          cmd_wr_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  always_comb begin
    cmd_wr_d = sel ? m1_wr_i    : m0_wr_i;
    addr_d   = sel ? m1_addr_i  : m0_addr_i;
    wdata_d  = sel ? m1_wdata_i : m0_wdata_i;
  end

  // vld_pipe_q[1]: bus stage holds a command; vld_pipe_q[2]: read response.
  logic [2:1]    vld_pipe_q;
  logic          cmd_wr_q;
  mid_t          cmd_id_q, rsp_id_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rsp_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_pipe_q <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_id_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      vld_pipe_q[1] <= acc;
      vld_pipe_q[2] <= rd_o;
      // addr/wdata only move on an accept so the bus holds its last value.
      if (acc) begin
        cmd_wr_q <= cmd_wr_d;
        cmd_id_q <= sel;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
      end
      if (rd_o) begin
        rsp_id_q   <= cmd_id_q;
        rsp_data_q <= rdata_i;
      end
    end
  end

  assign rd_o    = vld_pipe_q[1] & ~cmd_wr_q;
  assign wr_o    = vld_pipe_q[1] &  cmd_wr_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_q;

  assign m0_rvalid_o = vld_pipe_q[2] & ~rsp_id_q;
  assign m1_rvalid_o = vld_pipe_q[2] &  rsp_id_q;
  assign m0_rdata_o  = rsp_data_q;
  assign m1_rdata_o  = rsp_data_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Self-checking bench for periph_bus_arbiter: expected bus commands and read
// responses are queued when a grant is expected and compared when due.
module tb_periph_bus_arbiter;
  import periph_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_wr = 0, m0_lock = 0, m1_req = 0, m1_wr = 0, m1_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, rd, wr;
  logic [31:0] m0_rdata, m1_rdata, addr, wdata, rdata;

  always #5 clk = ~clk;

  // Peripheral model: switches read 0xA5, other registers a fixed address hash.
  function automatic logic [31:0] periph_rd(input logic [31:0] a);
    if (a == ADDR_SWITCH) return 32'h0000_00A5;
    return ~a ^ 32'h1234_5678;
  endfunction

  assign rdata = periph_rd(addr);

  periph_bus_arbiter #(.AW(32), .DW(32), .MAX_LOCK(8)) dut (
    .clk_i(clk), .reset_i(reset),
    .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_lock_i(m0_lock), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_lock_i(m1_lock), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .rd_o(rd), .wr_o(wr), .addr_o(addr), .wdata_o(wdata), .rdata_i(rdata)
  );

  typedef struct { int due; logic wr; logic [31:0] addr; logic [31:0] wdata; } bus_t;
  typedef struct { int due; logic id; logic [31:0] data; } rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_chk = 0, n_fail = 0, cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // One clock cycle: drive inputs, check gnt and due pipeline outputs at the
  // negedge, queue expectations for expected accepts, then take the edge.
  task automatic cyc(input string tag, input logic [1:0] req, input logic [1:0] wrv,
                     input logic [1:0] lock, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [1:0] eg);
    logic [1:0] erw, erv;
    bus_t b;
    rsp_t r;
    m0_req = req[0]; m0_wr = wrv[0]; m0_lock = lock[0]; m0_addr = a0; m0_wdata = $urandom;
    m1_req = req[1]; m1_wr = wrv[1]; m1_lock = lock[1]; m1_addr = a1; m1_wdata = $urandom;
    @(negedge clk);
    chk({tag, "/gnt"}, 32'({m1_gnt, m0_gnt}), 32'(eg));
    erw = 2'b00;
    if (bus_q.size() > 0 && bus_q[0].due == cyc_n) begin
      b = bus_q.pop_front();
      erw = {b.wr, ~b.wr};
      chk({tag, "/addr"}, addr, b.addr);
      if (b.wr) chk({tag, "/wdata"}, wdata, b.wdata);
    end
    chk({tag, "/rdwr"}, 32'({wr, rd}), 32'(erw));
    erv = 2'b00;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc_n) begin
      r = rsp_q.pop_front();
      erv = r.id ? 2'b10 : 2'b01;
      chk({tag, "/rdata"}, r.id ? m1_rdata : m0_rdata, r.data);
    end
    chk({tag, "/rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'(erv));
    for (int i = 0; i < 2; i++) begin
      if (req[i] && eg[i] && !reset) begin
        b.due = cyc_n + 1; b.wr = wrv[i];
        b.addr = i ? m1_addr : m0_addr; b.wdata = i ? m1_wdata : m0_wdata;
        bus_q.push_back(b);
        if (!wrv[i]) begin
          r.due = cyc_n + 2; r.id = 1'(i); r.data = periph_rd(b.addr);
          rsp_q.push_back(r);
        end
      end
    end
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc("idle", 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("rst", 2'b11, 2'b00, 2'b00, ADDR_LED, ADDR_DIGI, 2'b00);
    bus_q.delete(); rsp_q.delete();
    cyc("rst", 2'b11, 2'b00, 2'b00, ADDR_LED, ADDR_DIGI, 2'b00);
    reset = 1'b0;
  endtask

  initial begin
    m0_req = 1; m1_req = 1;
    @(posedge clk); #1;
    cyc_n = 1;
    // Reset state: no grants while reset is high, quiet bus and response.
    cyc("rst", 2'b11, 2'b00, 2'b00, ADDR_LED, ADDR_DIGI, 2'b00);
    chk("rst/addr", addr, 32'h0);
    chk("rst/wdata", wdata, 32'h0);
    chk("rst/m0_rdata", m0_rdata, 32'h0);
    chk("rst/m1_rdata", m1_rdata, 32'h0);
    reset = 1'b0;

    // Single master read of the switches.
    cyc("rd_sw", 2'b01, 2'b00, 2'b00, ADDR_SWITCH, 0, 2'b01);
    idle(1);
    chk("rd_sw/data", m0_rdata, 32'h0000_00A5);
    idle(1);

    // Contention after reset: strict alternation starting with m0.
    do_reset();
    for (int i = 0; i < 6; i++)
      cyc("cont", 2'b11, 2'b11, 2'b00, ADDR_LED, ADDR_DIGI, (i % 2) ? 2'b10 : 2'b01);
    idle(2);

    // Lock: m0 alone first so m1 wins the contended lock entry.
    cyc("pre", 2'b01, 2'b01, 2'b00, ADDR_LED, 0, 2'b01);
    cyc("lk_txd", 2'b11, 2'b11, 2'b10, ADDR_LED, ADDR_UART_TXD, 2'b10);
    cyc("lk_con", 2'b11, 2'b01, 2'b00, ADDR_LED, ADDR_UART_CON, 2'b10);
    cyc("lk_m0", 2'b01, 2'b01, 2'b00, ADDR_LED, 0, 2'b01);
    idle(2);

    // Lock cap: m1 alone makes m0 the next round-robin winner.
    cyc("pre", 2'b10, 2'b10, 2'b00, 0, ADDR_DIGI, 2'b10);
    for (int i = 0; i < 8; i++)
      cyc("cap", 2'b11, 2'b11, 2'b01, ADDR_TCON, ADDR_DIGI, 2'b01);
    cyc("cap_m1", 2'b11, 2'b10, 2'b01, ADDR_TL, ADDR_UART_RXD, 2'b10);
    cyc("relock", 2'b11, 2'b11, 2'b01, ADDR_TCON, ADDR_DIGI, 2'b01);
    // Owner idle: m0 drops req, m1 granted same cycle and takes the lock.
    cyc("idle_m0", 2'b10, 2'b10, 2'b10, 0, ADDR_UART_TXD, 2'b10);
    cyc("own_m1", 2'b11, 2'b01, 2'b10, ADDR_LED, ADDR_UART_CON, 2'b10);
    cyc("idle_m1", 2'b01, 2'b00, 2'b00, ADDR_TH, 0, 2'b01);
    idle(2);

    // Reset in the cycle after a read accept: rd still shows, no rvalid.
    cyc("mid_rd", 2'b01, 2'b00, 2'b00, ADDR_TL, 0, 2'b01);
    reset = 1'b1;
    cyc("mid_rst", 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
    bus_q.delete(); rsp_q.delete();
    cyc("mid_rst2", 2'b01, 2'b00, 2'b00, ADDR_TL, 0, 2'b00);
    chk("mid_rst/addr", addr, 32'h0);
    reset = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master arbiter and request pipeline in front of the memory-mapped peripheral bus at 0x4000_0000 (timer, LEDs, switches, digits, UART registers). Master 0 is the CPU data port; master 1 is an auxiliary bus master such as a UART loader or DMA sequencer. The block grants one transfer per cycle with round-robin fairness and a bounded bus lock for atomic sequences. It registers the winning command onto the peripheral's rd/wr/addr/wdata, and returns read data to the owning master one cycle later.

## Interface
- AW, 32, address width
- DW, 32, data width
- MAX_LOCK, 8, maximum consecutive locked grants to one master (≥2)
- clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- m0_req / m1_req  in  1  transfer request, held until granted
- m0_wr / m1_wr  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  byte address
- m0_wdata / m1_wdata  in  DW  write data
- m0_lock / m1_lock  in  1  keep ownership after this transfer
- m0_gnt / m1_gnt  out  1  combinational; transfer accepted when req && gnt at the edge
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse
- m0_rdata / m1_rdata  out  DW  read data, valid with rvalid
- rd, wr  out  1  peripheral strobes
- addr  out  AW  peripheral address
- wdata  out  DW  peripheral write data
- rdata  in  DW  peripheral read data, combinational from rd/addr

## Operation
- Arbiter state: `last` (last granted master, reset = 1, so m0 wins first), `owner` (NONE/M0/M1, reset NONE), `lock_cnt` (reset 0).
- Unlocked arbitration:
  - If only one master requests, it is granted.
  - If both request, the master other than `last` is granted.
  - Each accepted grant updates `last`.
- Lock entry: an accepted transfer with lock=1 sets `owner` to that master and `lock_cnt` to 1.
- While `owner` ≠ NONE:
  - Only `owner` can be granted.
  - The other master's gnt is 0, even if the owner is idle.
  - Each locked accept increments `lock_cnt`.
- Lock release: `owner` returns to NONE on any of these:
  - the owner's accepted transfer has lock=0 (that transfer is still granted);
  - the owner's req is 0 in a cycle (release takes effect that same cycle, and the other master may be granted in that cycle);
  - `lock_cnt` reaches MAX_LOCK at accept. That transfer is granted. Next cycle, if the other master requests, it wins regardless of the owner's lock.
- Bus stage: an accepted command is registered.
  - The next cycle drives rd = ~wr_cmd, wr = wr_cmd, addr, and wdata for exactly one cycle.
  - With no accepted command, rd = wr = 0 and addr/wdata hold their previous values.
- Response stage:
  - In a bus cycle with rd = 1, rdata is captured together with the issuing master's id.
  - The next cycle pulses that master's rvalid with the captured data.
  - Writes produce no response.
- Throughput: one accept per cycle, back-to-back, including alternating masters. The pipeline never stalls.
- gnt depends only on req/lock inputs and registered state, with no path from rdata.

## Timing
- Reset values:
  - gnt = 0 while reset is high.
  - rd = wr = 0, addr = wdata = 0.
  - rvalid = 0, rdata = 0.
  - `owner` = NONE, `last` = 1, `lock_cnt` = 0.
- Read latency for an accept at edge k:
  - rd/addr are asserted in cycle k..k+1.
  - rvalid is asserted in cycle k+1..k+2.
  - Request-to-data latency is 2 cycles.
- Write latency: wr is asserted in the cycle after accept. The peripheral commits on the following edge.
- Reset asserted mid-operation: all in-flight bus and response stages are discarded. No rd, wr or rvalid is issued after the reset edge.
- Simultaneous lock request by both masters with owner = NONE: the normal round-robin winner takes the lock.

## Structure
- Package `periph_bus_pkg`:
  - owner enum (NONE, M0, M1);
  - master-id type;
  - peripheral address constants: TH 0x4000_0000, TL 0x04, TCON 0x08, LED 0x0C, SWITCH 0x10, DIGI 0x14, UART_TXD 0x18, UART_RXD 0x1C, UART_CON 0x20.
- Sub-module `arb2_rr_lock` holds the grant logic, `last`, `owner` and `lock_cnt`. The top level contains the bus and response registers.

## Test plan
- Single master read: m0 reads 0x4000_0010 with switch = 0xA5. rd pulses at k+1, and m0_rvalid pulses at k+2 with rdata 0x0000_00A5. m1_rvalid stays 0.
- Contention:
  - Both masters request writes continuously after reset.
  - Grants alternate m0, m1, m0, m1.
  - wr is high every cycle with the matching addr/wdata.
- Lock:
  - m1 writes TXD (0x18) with lock = 1, then reads UART_CON (0x20) with lock = 0, while m0 requests throughout.
  - m0 gnt stays 0 for both m1 transfers, then m0 is granted on the next cycle.
- Lock cap:
  - With MAX_LOCK = 8, m0 holds lock = 1 and requests continuously while m1 requests.
  - m0 gets exactly 8 grants, then m1 is granted.
- Owner idle: m1 holds the lock, then drops req for one cycle while m0 requests. m0 is granted in that same cycle.
- Reset mid-read: reset is asserted in the cycle after a read accept. No rvalid is issued, and rd = wr = 0 from the next edge.
